// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant and direct handoff.
// Optional ARB_TIMEOUT_EN bounds each grant to HOLD_MAX cycles with a forced release.
module rr_arbiter_8 #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Reject configurations where the hold counter cannot reach HOLD_MAX-1.
  if (HOLD_MAX < 2 || HOLD_MAX > 255 || CNT_W > 31 || (32'd1 << CNT_W) <= HOLD_MAX) begin : g_cfg_err
    $error("rr_arbiter_8: illegal HOLD_MAX/CNT_W combination");
  end

  // Shared 3-to-8 one-hot decode.
  function automatic logic [N-1:0] dec3to8(input logic [IW-1:0] i);
    dec3to8 = N'(1) << i;
  endfunction

  // First set bit of r at or after p, wrapping 7->0.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    rr_pick = p;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = p + IW'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] idx_n;
  logic [N-1:0]  gnt_n;
  logic          vld_n;

  logic          hold_bit;
  logic [N-1:0]  others;
  logic [N-1:0]  pick_req;
  logic [IW-1:0] pick_base;
  logic [IW-1:0] win;
  logic          force_rel;

  assign hold_bit  = req[gnt_idx];
  assign others    = req & ~dec3to8(gnt_idx);
  assign pick_req  = (state == IDLE) ? req : others;
  assign pick_base = (state == IDLE) ? ptr : gnt_idx + IW'(1);
  assign win       = rr_pick(pick_req, pick_base);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             timeout_n;

  assign force_rel = (state == GRANT) && hold_bit && (cnt == CNT_W'(HOLD_MAX - 1));
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and next-output decision.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    gnt_n   = gnt;
    vld_n   = gnt_vld;
`ifdef ARB_TIMEOUT_EN
    cnt_n     = cnt;
    timeout_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (en && (|req)) begin
          state_n = GRANT;
          idx_n   = win;
          gnt_n   = dec3to8(win);
          vld_n   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      GRANT: begin
        if (!hold_bit || force_rel) begin
          ptr_n = gnt_idx + IW'(1);
`ifdef ARB_TIMEOUT_EN
          timeout_n = force_rel;
          cnt_n     = '0;
`endif
          if (en && (|others)) begin
            idx_n = win;
            gnt_n = dec3to8(win);
          end else if (!(force_rel && en)) begin
            // A forced holder with no competitor keeps gnt; everyone else goes idle.
            state_n = IDLE;
            gnt_n   = '0;
            vld_n   = 1'b0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_n = cnt + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        vld_n   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_idx <= idx_n;
      gnt     <= gnt_n;
      gnt_vld <= vld_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and forced-release pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      timeout <= timeout_n;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic against an owner/queue-level model.
module tb_rr_arbiter_8;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD  = 4;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned HOLD  = 16;
  localparam bit          TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the resource (-1 none), last winner, priority start, cycles held so far.
  int m_owner, m_last, m_ptr, m_held;
  bit m_to;

  rr_arbiter_8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++)
      if (r[3'((start + k) % 8)]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    logic [7:0] rest;
    bit forced;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (e && r != 8'h00) begin
        m_owner = pick(r, m_ptr); m_last = m_owner; m_held = 1;
      end
    end else begin
      forced = TO_EN && (m_held == int'(HOLD)) && r[3'(m_owner)];
      if (!r[3'(m_owner)] || forced) begin
        m_ptr = (m_owner + 1) % 8;
        rest = r;
        rest[3'(m_owner)] = 1'b0;
        m_to = forced;
        if (e && rest != 8'h00) begin
          m_owner = pick(rest, m_ptr); m_last = m_owner; m_held = 1;
        end else if (forced && e) begin
          m_held = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/gnt"},     32'(gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, "/gnt_idx"}, 32'(gnt_idx), 32'(m_last));
    check({tag, "/gnt_vld"}, 32'(gnt_vld), (m_owner < 0) ? 32'd0 : 32'd1);
    check({tag, "/timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic [7:0] r, input logic e, input string tag);
    req = r; en = e;
    @(posedge clk);
    model_step(r, e);
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] prev_gnt;
    int order[$];
    int idle_cycles;
    int n_to;

    rst = 1'b1; en = 1'b0; req = 8'h00;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all("reset");
    rst = 1'b0;

    // Single request, grant one cycle later, release keeps index.
    cycle(8'h10, 1'b1, "single");
    check("single_gnt", 32'(gnt), 32'h10);
    check("single_idx", 32'(gnt_idx), 32'd4);
    cycle(8'h00, 1'b1, "drop");
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_idx", 32'(gnt_idx), 32'd4);

    // Rotation with all requesting; each holder drops its bit after two grant cycles.
    do_reset("rot_rst");
    prev_gnt = 8'h00; idle_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      r = 8'hFF;
      if (m_owner >= 0 && m_held >= 2) r[3'(m_owner)] = 1'b0;
      cycle(r, 1'b1, "rot");
      if (!gnt_vld) idle_cycles++;
      if (gnt != prev_gnt && gnt != 8'h00) order.push_back(int'(gnt_idx));
      prev_gnt = gnt;
    end
    check("rot_no_bubble", 32'(idle_cycles), 32'd0);
    check("rot_count_ok", 32'(order.size() >= 9), 32'd1);
    for (int k = 0; k < 9 && k < order.size(); k++)
      check("rot_order", 32'(order[k]), 32'(k % 8));

    // Wrap: grant 6 so ptr becomes 7, then 7 and 0 compete.
    do_reset("wrap_rst");
    cycle(8'h40, 1'b1, "wrap6");
    cycle(8'h81, 1'b1, "wrap7");
    check("wrap_first7", 32'(gnt), 32'h80);
    cycle(8'h81, 1'b1, "wrap_hold");
    cycle(8'h01, 1'b1, "wrap0");
    check("wrap_then0", 32'(gnt), 32'h01);

    // Enable gating.
    do_reset("en_rst");
    cycle(8'h04, 1'b1, "en_g2");
    cycle(8'h24, 1'b0, "en_hold");
    check("en_keep2", 32'(gnt), 32'h04);
    cycle(8'h24, 1'b0, "en_hold2");
    cycle(8'h20, 1'b0, "en_rel");
    check("en_rel_zero", 32'(gnt), 32'h00);
    cycle(8'h20, 1'b1, "en_on");
    check("en_g5", 32'(gnt), 32'h20);

    // Asynchronous reset between edges while 3 holds the grant.
    do_reset("ar_rst");
    cycle(8'h08, 1'b1, "ar_g3");
    check("ar_pre", 32'(gnt), 32'h08);
    #2;
    rst = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt), 32'h00);
    check("ar_vld", 32'(gnt_vld), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Two permanent requesters alternate, each forced off after HOLD cycles.
    do_reset("tmo_rst");
    n_to = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(8'h03, 1'b1, "tmo");
      if (timeout) n_to++;
    end
    check("tmo_pulses", 32'(n_to), 32'd4);
    // Lone requester is regranted with timeout still pulsing.
    do_reset("tmo1_rst");
    for (int c = 0; c < 10; c++) cycle(8'h01, 1'b1, "tmo_solo");
`endif

    // Random traffic with sticky requests, gated enable and occasional reset.
    do_reset("rnd_rst");
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_arst");
      r = r ^ (8'($urandom) & 8'($urandom));
      cycle(r, ($urandom_range(0, 7) != 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
